// File: rtl/m_dm_lanes.sv
// m_dm_lanes: byte/half/word data memory for the M stage with configurable access latency.
// Optional feature: define DM_TRACE_EN to print every committed store.
module m_dm_lanes #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades
);
  localparam int          ADDR_W = $clog2(DEPTH_WORDS * 4);
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
  localparam bit          COMB   = (LATENCY == 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        signExt_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]       reqOff;
  logic              misaligned;
  logic              outOfRange;
  logic              excAny;
  logic              accept;
  logic              complete;
  logic [31:0]       actAddr;
  logic [31:0]       actWdata;
  logic [31:0]       actPc;
  logic [1:0]        actSize;
  logic              actWe;
  logic              actSignExt;
  logic [ADDR_W-1:0] actOff;
  logic [ADDR_W-3:0] wordIdx;
  logic [1:0]        lane;
  logic [31:0]       oldWord;
  logic [31:0]       merged;
  logic [31:0]       loadVal;
  logic [7:0]        laneByte;
  logic [15:0]       laneHalf;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign reqOff     = addr - BASE_ADDR;
  assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign outOfRange = (reqOff >= SPAN);
  assign excAny     = (state_q == IDLE) && req && (misaligned || outOfRange);
  assign exc_adel   = excAny && !we;
  assign exc_ades   = excAny && we;
  assign accept     = (state_q == IDLE) && req && !(misaligned || outOfRange);
  assign complete   = COMB ? accept : ((state_q == WAIT) && (cnt_q == 2'd0));
  assign ready      = excAny || complete;
  assign stall      = !COMB && (accept || ((state_q == WAIT) && (cnt_q != 2'd0)));

  // With zero latency the live inputs drive the access; otherwise the latched copy does.
  assign actAddr    = COMB ? addr     : addr_q;
  assign actWdata   = COMB ? wdata    : wdata_q;
  assign actPc      = COMB ? pc       : pc_q;
  assign actSize    = COMB ? size     : size_q;
  assign actWe      = COMB ? we       : we_q;
  assign actSignExt = COMB ? sign_ext : signExt_q;

  assign actOff   = ADDR_W'(actAddr - BASE_ADDR);
  assign wordIdx  = actOff[ADDR_W-1:2];
  assign lane     = actOff[1:0];
  assign oldWord  = mem[wordIdx];
  assign laneByte = oldWord[{lane, 3'b000} +: 8];
  assign laneHalf = oldWord[{lane[1], 4'b0000} +: 16];

  always_comb begin
    merged  = oldWord;
    loadVal = oldWord;
    case (actSize)
      2'b00: begin
        merged[{lane, 3'b000} +: 8] = actWdata[7:0];
        loadVal = {{24{actSignExt & laneByte[7]}}, laneByte};
      end
      2'b01: begin
        merged[{lane[1], 4'b0000} +: 16] = actWdata[15:0];
        loadVal = {{16{actSignExt & laneHalf[15]}}, laneHalf};
      end
      default: merged = actWdata;
    endcase
  end

  assign rdata = excAny ? 32'h0 : ((COMB && complete && !actWe) ? loadVal : rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      rdata_q   <= 32'h0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      pc_q      <= 32'h0;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      signExt_q <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else begin
      if (complete && actWe) mem[wordIdx] <= merged;
      if (complete && !actWe) rdata_q <= loadVal;
      else if (excAny) rdata_q <= 32'h0;
      case (state_q)
        IDLE: begin
          if (accept && !COMB) begin
            state_q   <= WAIT;
            cnt_q     <= 2'(LATENCY - 1);
            addr_q    <= addr;
            wdata_q   <= wdata;
            pc_q      <= pc;
            size_q    <= size;
            we_q      <= we;
            signExt_q <= sign_ext;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) state_q <= IDLE;
          else cnt_q <= cnt_q - 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && complete && actWe)
      $display("%d@%h: *%h <= %h", $time, actPc - 32'd4, {actAddr[31:2], 2'b00}, merged);
  end
`else
  logic unusedPc;
  assign unusedPc = ^actPc;
`endif

endmodule

// File: tb/tb_m_dm_lanes.sv
// tb_m_dm_lanes: scoreboard bench for m_dm_lanes at latencies 0, 2 and 3 against a byte-array model.
module tb_m_dm_lanes;
  localparam int          NI    = 3;
  localparam int          DEPTH = 256;
  localparam int          BYTES = DEPTH * 4;
  localparam int          LAT  [NI] = '{0, 2, 3};
  localparam logic [31:0] BASE [NI] = '{32'h0, 32'h1000, 32'h0};

  typedef struct {
    int          inst;
    logic        isLoad;
    logic        adel;
    logic        ades;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst      [NI];
  logic [31:0] pc       [NI];
  logic        req      [NI];
  logic        we       [NI];
  logic [1:0]  size     [NI];
  logic        signExt  [NI];
  logic [31:0] addr     [NI];
  logic [31:0] wdata    [NI];
  logic [31:0] rdata    [NI];
  logic        ready    [NI];
  logic        stall    [NI];
  logic        excAdel  [NI];
  logic        excAdes  [NI];

  logic [7:0]  mdl      [NI][BYTES];
  exp_t        sb[$];
  logic        pendData [NI];
  logic [31:0] pendVal  [NI];
  int          errors = 0;
  int          checks = 0;

  m_dm_lanes #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE[0]), .LATENCY(LAT[0])) dut0 (
    .clk(clk), .rst(rst[0]), .pc(pc[0]), .req(req[0]), .we(we[0]), .size(size[0]),
    .sign_ext(signExt[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .ready(ready[0]), .stall(stall[0]), .exc_adel(excAdel[0]), .exc_ades(excAdes[0]));
  m_dm_lanes #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE[1]), .LATENCY(LAT[1])) dut1 (
    .clk(clk), .rst(rst[1]), .pc(pc[1]), .req(req[1]), .we(we[1]), .size(size[1]),
    .sign_ext(signExt[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .ready(ready[1]), .stall(stall[1]), .exc_adel(excAdel[1]), .exc_ades(excAdes[1]));
  m_dm_lanes #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE[2]), .LATENCY(LAT[2])) dut2 (
    .clk(clk), .rst(rst[2]), .pc(pc[2]), .req(req[2]), .we(we[2]), .size(size[2]),
    .sign_ext(signExt[2]), .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]),
    .ready(ready[2]), .stall(stall[2]), .exc_adel(excAdel[2]), .exc_ades(excAdes[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearModel(input int k);
    for (int i = 0; i < BYTES; i++) mdl[k][i] = 8'h00;
  endtask

  // Reference: memory as a flat little-endian byte array; exceptions from the address rules.
  task automatic modelAccess(input int k, input logic wr, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    logic [31:0] off;
    logic [31:0] v;
    int          n;
    int          start;
    logic        bad;
    off = a - BASE[k];
    bad = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)) || (off >= 32'(BYTES));
    n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    e.inst = k; e.isLoad = !wr; e.adel = bad && !wr; e.ades = bad && wr; e.data = 32'h0;
    if (!bad) begin
      start = int'(off) - (int'(off) % n);
      if (wr) begin
        for (int i = 0; i < n; i++) mdl[k][start + i] = 8'(wd >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[k][start + i]) << (8 * i));
        if (sx && (n < 4) && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        e.data = v;
      end
    end
  endtask

  // One access: present it, wait for ready, count stall cycles on the way.
  task automatic applyStimulus(input int k, input logic wr, input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   stalls;
    int   waited;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = wr; size[k] = sz; signExt[k] = sx; addr[k] = a; wdata[k] = wd;
    pc[k] = 32'h0040_0000 + 32'($urandom_range(0, 255) * 4);
    modelAccess(k, wr, sz, sx, a, wd, e);
    sb.push_back(e);
    stalls = 0;
    waited = 0;
    forever begin
      @(negedge clk);
      if (ready[k]) break;
      if (stall[k]) stalls++;
      waited++;
      if (waited > 10) break;
    end
    checkOutput($sformatf("ready_timeout[%0d]", k), 32'(ready[k]), 32'd1);
    checkOutput($sformatf("stall_cycles[%0d]@%h", k, a), 32'(stalls),
                (e.adel || e.ades) ? 32'd0 : 32'(LAT[k]));
    if (LAT[k] != 0) begin
      @(posedge clk); #1;
      req[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idleCycles(input int k, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      req[k] = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("idle_ready[%0d]", k), 32'(ready[k]), 32'd0);
      checkOutput($sformatf("idle_stall[%0d]", k), 32'(stall[k]), 32'd0);
      checkOutput($sformatf("idle_exc[%0d]", k), {30'h0, excAdel[k], excAdes[k]}, 32'd0);
    end
  endtask

  task automatic randomRun(input int k, input int count);
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = BASE[k] + 32'($urandom_range(0, BYTES + 40)) - 32'd16;
      if ($urandom_range(0, 3) != 0) a = (sz == 2'b00) ? a : ((sz == 2'b01) ? (a & ~32'd1) : (a & ~32'd3));
      applyStimulus(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 7) == 0) idleCycles(k, 1);
    end
  endtask

  // Monitor: pops the scoreboard whenever any instance reports ready.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (pendData[k]) begin
        checkOutput($sformatf("rdata_reg[%0d]", k), rdata[k], pendVal[k]);
        pendData[k] = 1'b0;
      end
      if (ready[k]) begin
        if (sb.size() == 0) begin
          checkOutput($sformatf("spurious_ready[%0d]", k), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput($sformatf("sb_inst[%0d]", k), 32'(k), 32'(e.inst));
          checkOutput($sformatf("exc_adel[%0d]", k), 32'(excAdel[k]), 32'(e.adel));
          checkOutput($sformatf("exc_ades[%0d]", k), 32'(excAdes[k]), 32'(e.ades));
          checkOutput($sformatf("stall_at_ready[%0d]", k), 32'(stall[k]), 32'd0);
          if (e.adel || e.ades) checkOutput($sformatf("rdata_exc[%0d]", k), rdata[k], 32'h0);
          else if (e.isLoad && LAT[k] == 0) checkOutput($sformatf("rdata_comb[%0d]", k), rdata[k], e.data);
          else if (e.isLoad) begin
            pendData[k] = 1'b1;
            pendVal[k]  = e.data;
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'b00; signExt[k] = 1'b0;
      addr[k] = 32'h0; wdata[k] = 32'h0; pc[k] = 32'h0; pendData[k] = 1'b0; pendVal[k] = 32'h0;
      clearModel(k);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
      checkOutput($sformatf("reset_ready[%0d]", k), 32'(ready[k]), 32'd0);
      checkOutput($sformatf("reset_stall[%0d]", k), 32'(stall[k]), 32'd0);
    end

    // Zero latency: directed lane tests, back-to-back, then exceptions.
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AB);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("const_sb_merge", rdata[0], 32'hAB34_5678);
    applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    checkOutput("const_lh", rdata[0], 32'hFFFF_8001);
    applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkOutput("const_sh_word", rdata[0], 32'h8001_0000);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'(BYTES), 32'hFFFF_FFFF);
    applyStimulus(0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    idleCycles(0, 2);
    randomRun(0, 150);
    idleCycles(0, 1);

    // Latency 2 with a nonzero base so low addresses wrap into the range error.
    applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h1010, 32'hCAFE_F00D);
    applyStimulus(1, 1'b0, 2'b00, 1'b1, 32'h1012, 32'h0);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0);
    randomRun(1, 60);
    idleCycles(1, 1);

    // Latency 3: a store aborted by reset one cycle after acceptance.
    applyStimulus(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h44; wdata[2] = 32'h1111_1111;
    @(negedge clk);
    checkOutput("rst_abort_stall_accept", 32'(stall[2]), 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1; req[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    clearModel(2);
    @(negedge clk);
    checkOutput("rst_abort_stall", 32'(stall[2]), 32'd0);
    checkOutput("rst_abort_ready", 32'(ready[2]), 32'd0);
    checkOutput("rst_abort_rdata", rdata[2], 32'h0);
    applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    randomRun(2, 30);
    idleCycles(2, 2);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
